memory_arbiter: RTL and testbench

- Shares the core's single memory bus (memoryEnable / memoryReadWrite / memoryAddress / memoryData / memoryReady) between two requesters.
- Requesters: instruction fetch (read-only) and load/store (read/write).
- Sits between the LUMOS fetch/LSU logic and the memory.
- Serializes one access at a time and returns a one-cycle ready pulse plus data to the winning requester.

---
 rtl/memory_arbiter_pkg.sv | 43 ++++
 rtl/memory_arbiter_timer.sv | 39 +++
 rtl/memory_arbiter.sv | 175 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_pkg
// Description : Shared encodings for the fetch / load-store memory arbiter.
//               Holds bus-level enable and direction values, FSM state and
//               grant encodings, and the grant-selection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

  // Bus-level encodings shared with the rest of the core
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  // Chooses the winner among pending requests. Under contention either the
  // data side always wins, or the side recorded in rr_next is taken.
  function automatic grant_e pick_grant(input logic   fetch_req,
                                        input logic   data_req,
                                        input logic   data_first,
                                        input grant_e rr_next);
    if (fetch_req && data_req)
      return data_first ? GRANT_DATA : rr_next;
    else if (data_req)
      return GRANT_DATA;
    else
      return GRANT_FETCH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_timer.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_timer
// Description : Read watchdog for the memory arbiter. Counts cycles while a
//               read is outstanding and flags expiry on the LIMIT-th cycle.
// Ports       : clk      - clock
//               reset    - synchronous active-high reset
//               clear    - zero the counter (held while no access is active)
//               count_en - a read is waiting in the access phase
//               expired  - current cycle is the LIMIT-th waiting cycle
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [CW-1:0] count;

  // count holds the number of completed waiting cycles, so the current cycle
  // is the LIMIT-th one when count equals LIMIT-1.
  assign expired = count_en && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (count_en && !expired)
      count <= count + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one memory bus between instruction fetch (read-only)
//               and load/store (read/write). One access at a time; the winner
//               receives a one-cycle ready pulse plus read data.
// Optional    : MEMORY_ARBITER_TIMEOUT_EN adds a read watchdog that completes a
//               stalled read with zero data and sets sticky memoryTimeout.
// Ports       : clk, reset                          - clock, sync active-high reset
//               fetchRequest/Address/Ready/Data      - fetch requester
//               dataRequest/ReadWrite/Address/
//               WriteData/Ready/ReadData             - load/store requester
//               memoryEnable/ReadWrite/Address/Data  - memory bus
//               memoryReady                          - memory read data valid
//               memoryTimeout                        - sticky read timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY  = 1,
  parameter int WRITE_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetchRequest,
  input  logic [31:0] fetchAddress,
  output logic        fetchReady,
  output logic [31:0] fetchData,
  input  logic        dataRequest,
  input  logic        dataReadWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataWriteData,
  output logic        dataReady,
  output logic [31:0] dataReadData,
  output logic        memoryEnable,
  output logic        memoryReadWrite,
  output logic [31:0] memoryAddress,
  inout  wire  [31:0] memoryData,
  input  logic        memoryReady,
  output logic        memoryTimeout
);

  localparam int             WCW        = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [WCW-1:0] WRITE_LAST = WCW'(WRITE_CYCLES - 1);

  arb_state_e     state, state_next;
  grant_e         grant, grant_sel, rr_next;
  logic           rw;
  logic [31:0]    addr, wdata, read_value;
  logic [WCW-1:0] write_count;
  logic           any_request, read_done, write_done, access_done;
  logic           timeout_hit, bus_drive;

  assign any_request = fetchRequest | dataRequest;
  assign grant_sel   = pick_grant(fetchRequest, dataRequest, DATA_PRIORITY != 0, rr_next);
  assign read_done   = (rw == READ) && (memoryReady || timeout_hit);
  assign write_done  = (rw == WRITE) && (write_count == WRITE_LAST);
  assign access_done = read_done || write_done;
  // A watchdog completion returns zero rather than whatever floats on the bus
  assign read_value  = memoryReady ? memoryData : '0;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset)
      state <= ARB_IDLE;
    else
      state <= state_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:   if (any_request) state_next = ARB_ACCESS;
      ARB_ACCESS: if (access_done) state_next = ARB_DONE;
      ARB_DONE:   state_next = ARB_IDLE;   // one dead cycle lets requesters drop
      default:    state_next = ARB_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    memoryEnable = DISABLE;
    bus_drive    = 1'b0;
    if (state == ARB_ACCESS) begin
      memoryEnable = ENABLE;
      bus_drive    = (rw == WRITE);
    end
  end

  assign memoryReadWrite = rw;
  assign memoryAddress   = addr;
  assign memoryData      = bus_drive ? wdata : 'z;

  // ---------------- request latch and completion datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      grant        <= GRANT_FETCH;
      rr_next      <= GRANT_FETCH;
      rw           <= READ;
      addr         <= '0;
      wdata        <= '0;
      write_count  <= '0;
      fetchReady   <= 1'b0;
      dataReady    <= 1'b0;
      fetchData    <= '0;
      dataReadData <= '0;
    end else begin
      fetchReady <= 1'b0;
      dataReady  <= 1'b0;

      if (state == ARB_IDLE && any_request) begin
        grant       <= grant_sel;
        rr_next     <= (grant_sel == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
        write_count <= '0;
        wdata       <= dataWriteData;
        if (grant_sel == GRANT_DATA) begin
          addr <= dataAddress;
          rw   <= dataReadWrite;
        end else begin
          addr <= fetchAddress;
          rw   <= READ;          // fetch is read-only
        end
      end

      if (state == ARB_ACCESS) begin
        if (write_done)
          dataReady <= 1'b1;
        else if (rw == WRITE)
          write_count <= write_count + 1'b1;

        if (read_done) begin
          if (grant == GRANT_DATA) begin
            dataReady    <= 1'b1;
            dataReadData <= read_value;
          end else begin
            fetchReady   <= 1'b1;
            fetchData    <= read_value;
          end
        end
      end
    end
  end

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  logic timeout_flag;

  memory_arbiter_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != ARB_ACCESS),
    .count_en ((state == ARB_ACCESS) && (rw == READ)),
    .expired  (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (reset)
      timeout_flag <= 1'b0;
    else if (timeout_hit && !memoryReady)
      timeout_flag <= 1'b1;
  end

  assign memoryTimeout = timeout_flag;
`else
  assign timeout_hit   = 1'b0;
  // Watchdog absent: flag is constant; the limit only qualifies the constant
  assign memoryTimeout = DISABLE & (TIMEOUT_CYCLES > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Directed self-checking bench for memory_arbiter. One instance
//               uses data priority with a word memory model; a second uses
//               round-robin with a memory that answers immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // ---------------- priority instance ----------------
  logic        f_req, f_rdy, d_req, d_rw, d_rdy, m_en, m_rw, m_rdy, m_to;
  logic [31:0] f_addr, f_data, d_addr, d_wdata, d_rdata, m_addr;
  tri1  [31:0] m_bus;
  logic [31:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  memory_arbiter #(
    .DATA_PRIORITY (1),
    .WRITE_CYCLES  (1),
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clk(clk), .reset(reset),
    .fetchRequest(f_req), .fetchAddress(f_addr), .fetchReady(f_rdy), .fetchData(f_data),
    .dataRequest(d_req), .dataReadWrite(d_rw), .dataAddress(d_addr),
    .dataWriteData(d_wdata), .dataReady(d_rdy), .dataReadData(d_rdata),
    .memoryEnable(m_en), .memoryReadWrite(m_rw), .memoryAddress(m_addr),
    .memoryData(m_bus), .memoryReady(m_rdy), .memoryTimeout(m_to)
  );

  // Memory drives the bus for enabled reads; writes land on the clock edge
  assign m_bus = (m_en && m_rw == READ) ? mem[m_addr[9:2]] : 'z;

  always @(posedge clk) begin
    if (pre_en)
      mem[pre_idx] <= pre_val;
    else if (m_en && m_rw == WRITE)
      mem[m_addr[9:2]] <= m_bus;
  end

  // ---------------- round-robin instance ----------------
  logic        rf_req, rd_req, rr_frdy, rr_drdy, rr_en, rr_rw, rr_to;
  logic [31:0] rr_fdata, rr_drdata, rr_addr;
  wire  [31:0] rr_bus;

  memory_arbiter #(
    .DATA_PRIORITY (0),
    .WRITE_CYCLES  (1),
    .TIMEOUT_CYCLES(8)
  ) u_rr (
    .clk(clk), .reset(reset),
    .fetchRequest(rf_req), .fetchAddress(32'h4), .fetchReady(rr_frdy), .fetchData(rr_fdata),
    .dataRequest(rd_req), .dataReadWrite(READ), .dataAddress(32'h8),
    .dataWriteData(32'h0), .dataReady(rr_drdy), .dataReadData(rr_drdata),
    .memoryEnable(rr_en), .memoryReadWrite(rr_rw), .memoryAddress(rr_addr),
    .memoryData(rr_bus), .memoryReady(rr_en), .memoryTimeout(rr_to)
  );

  // Immediate memory: returns the address as data
  assign rr_bus = (rr_en && rr_rw == READ) ? rr_addr : 'z;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    tick();
    pre_en  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total = 0;  bad = 0;
    reset = 1'b1;
    f_req = 1'b0;  f_addr = '0;
    d_req = 1'b0;  d_rw = READ;  d_addr = '0;  d_wdata = '0;
    m_rdy = 1'b0;
    pre_en = 1'b0;  pre_idx = '0;  pre_val = '0;
    rf_req = 1'b0;  rd_req = 1'b0;

    tick(2);
    check("rst_en",     {31'b0, m_en},    32'h0);
    check("rst_rw",     {31'b0, m_rw},    {31'b0, READ});
    check("rst_addr",   m_addr,           32'h0);
    check("rst_frdy",   {31'b0, f_rdy},   32'h0);
    check("rst_drdy",   {31'b0, d_rdy},   32'h0);
    check("rst_fdata",  f_data,           32'h0);
    check("rst_ddata",  d_rdata,          32'h0);
    check("rst_to",     {31'b0, m_to},    32'h0);
    check("rst_bus",    m_bus,            32'hFFFF_FFFF);

    preload(8'h04, 32'h0050_0093);
    preload(8'h00, 32'h1111_1111);
    preload(8'h40, 32'h2222_2222);
    preload(8'h80, 32'h0000_0000);
    reset = 1'b0;
    tick();

    // Single fetch with a delayed memory
    f_req = 1'b1;  f_addr = 32'h10;
    tick();
    check("fetch_en",       {31'b0, m_en},  32'h1);
    check("fetch_addr",     m_addr,         32'h10);
    tick(2);
    check("fetch_wait_rdy", {31'b0, f_rdy}, 32'h0);
    check("fetch_wait_en",  {31'b0, m_en},  32'h1);
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    check("fetch_rdy",      {31'b0, f_rdy}, 32'h1);
    check("fetch_data",     f_data,         32'h0050_0093);
    check("fetch_en_drop",  {31'b0, m_en},  32'h0);
    // Request still held through DONE: must not be re-granted
    tick();
    check("done_no_grant",  {31'b0, m_en},  32'h0);
    check("done_rdy_pulse", {31'b0, f_rdy}, 32'h0);
    f_req = 1'b0;
    tick();
    check("idle_no_grant",  {31'b0, m_en},  32'h0);

    // Simultaneous requests, data priority
    f_req = 1'b1;  f_addr = 32'h0;
    d_req = 1'b1;  d_rw = READ;  d_addr = 32'h100;
    tick();
    check("pri_first_addr", m_addr,         32'h100);
    check("pri_first_en",   {31'b0, m_en},  32'h1);
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;  d_req = 1'b0;
    check("pri_d_rdy",      {31'b0, d_rdy}, 32'h1);
    check("pri_d_data",     d_rdata,        32'h2222_2222);
    check("pri_f_quiet",    {31'b0, f_rdy}, 32'h0);
    tick();
    check("pri_done_en",    {31'b0, m_en},  32'h0);
    tick();
    check("pri_second_addr", m_addr,        32'h0);
    check("pri_second_en",  {31'b0, m_en},  32'h1);
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;  f_req = 1'b0;
    check("pri_f_rdy",      {31'b0, f_rdy}, 32'h1);
    check("pri_f_data",     f_data,         32'h1111_1111);
    check("pri_d_quiet",    {31'b0, d_rdy}, 32'h0);
    tick();

    // Store; memoryReady held high to show it is ignored for writes
    d_req = 1'b1;  d_rw = WRITE;  d_addr = 32'h200;  d_wdata = 32'hDEAD_BEEF;
    m_rdy = 1'b1;
    tick();
    check("st_en",          {31'b0, m_en},  32'h1);
    check("st_rw",          {31'b0, m_rw},  {31'b0, WRITE});
    check("st_bus",         m_bus,          32'hDEAD_BEEF);
    tick();
    d_req = 1'b0;  d_rw = READ;  m_rdy = 1'b0;
    check("st_rdy",         {31'b0, d_rdy}, 32'h1);
    check("st_en_drop",     {31'b0, m_en},  32'h0);
    check("st_mem",         mem[8'h80],     32'hDEAD_BEEF);
    check("st_bus_release", m_bus,          32'hFFFF_FFFF);
    check("st_rdata_kept",  d_rdata,        32'h2222_2222);
    tick();

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    // Memory never answers: watchdog completes the read on ACCESS cycle 8
    f_req = 1'b1;  f_addr = 32'h10;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_wait", {31'b0, f_rdy}, 32'h0);
    end
    tick();
    check("to_rdy",    {31'b0, f_rdy}, 32'h1);
    check("to_data",   f_data,         32'h0);
    check("to_flag",   {31'b0, m_to},  32'h1);
    f_req = 1'b0;
    tick(2);
    check("to_sticky", {31'b0, m_to},  32'h1);
`endif

    // Reset two cycles into a read
    f_req = 1'b1;  f_addr = 32'h10;
    tick();
    check("rm_en",        {31'b0, m_en},  32'h1);
    tick();
    reset = 1'b1;
    tick();
    check("rm_en_low",    {31'b0, m_en},  32'h0);
    check("rm_no_rdy",    {31'b0, f_rdy}, 32'h0);
    check("rm_to_clear",  {31'b0, m_to},  32'h0);
    reset = 1'b0;  f_req = 1'b0;  m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    check("rm_late_rdy",  {31'b0, f_rdy}, 32'h0);
    check("rm_late_en",   {31'b0, m_en},  32'h0);
    check("rm_fdata",     f_data,         32'h0);
    tick();

    // Round-robin under constant contention: fetch, data, fetch
    rf_req = 1'b1;  rd_req = 1'b1;
    tick();
    check("rr1_addr",  rr_addr,           32'h4);
    check("rr1_en",    {31'b0, rr_en},    32'h1);
    tick();
    check("rr1_frdy",  {31'b0, rr_frdy},  32'h1);
    check("rr1_drdy",  {31'b0, rr_drdy},  32'h0);
    tick(2);
    check("rr2_addr",  rr_addr,           32'h8);
    tick();
    check("rr2_drdy",  {31'b0, rr_drdy},  32'h1);
    check("rr2_data",  rr_drdata,         32'h8);
    tick(2);
    check("rr3_addr",  rr_addr,           32'h4);
    rf_req = 1'b0;  rd_req = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
